// File: rtl/game_level_ctrl.sv
// ---------------------------------------------------------------------------
// game_level_ctrl
//
// Difficulty / progress controller for the number-guessing game. Tracks the
// current level, correct guesses in the level, misses against a per-level
// budget and a per-level countdown, and tells the target generator when a
// fresh target is needed.
//
// Ports
//   clk            system clock
//   restart        asynchronous active-low reset
//   guess_valid    one-cycle strobe, a guess was submitted
//   guess_correct  qualifies guess_valid (1 = correct)
//   tick           one-cycle 1 Hz enable for the countdown
//   pause          level-sensitive pause request
//   level          current level, 0-based
//   max_digit      level+1, highest digit the target generator may use
//   win_or_lose    11 playing, 10 paused, 01 win, 00 lose
//   guesses_left   remaining misses in this level
//   time_left      remaining ticks in this level
//   round_count    correct guesses in this level
//   level_up       one-cycle pulse on level advance
//   new_target     one-cycle pulse requesting a fresh target
// ---------------------------------------------------------------------------
module game_level_ctrl #(
  parameter int NUM_LEVELS       = 3,
  parameter int ROUNDS_PER_LEVEL = 3,
  parameter int LVL_W            = 2,
  parameter int RND_W            = 3,
  parameter int MISS_W           = 3,
  parameter int BASE_MISSES      = 3,
  parameter int MISS_STEP        = 1,
  parameter int TIMER_W          = 7,
  parameter int LEVEL_TIME       = 99
) (
  input  logic               clk,
  input  logic               restart,
  input  logic               guess_valid,
  input  logic               guess_correct,
  input  logic               tick,
  input  logic               pause,
  output logic [LVL_W-1:0]   level,
  output logic [LVL_W-1:0]   max_digit,
  output logic [1:0]         win_or_lose,
  output logic [MISS_W-1:0]  guesses_left,
  output logic [TIMER_W-1:0] time_left,
  output logic [RND_W-1:0]   round_count,
  output logic               level_up,
  output logic               new_target
);

  typedef enum logic [2:0] {
    S_PLAY  = 3'd0,
    S_PAUSE = 3'd1,
    S_LVLUP = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  localparam logic [1:0] WOL_PLAY  = 2'b11;
  localparam logic [1:0] WOL_PAUSE = 2'b10;
  localparam logic [1:0] WOL_WIN   = 2'b01;
  localparam logic [1:0] WOL_LOSE  = 2'b00;

  // Miss budget grows linearly with the level.
  function automatic logic [MISS_W-1:0] budget(input logic [LVL_W-1:0] lvl);
    return MISS_W'(BASE_MISSES) + MISS_W'(lvl) * MISS_W'(MISS_STEP);
  endfunction

  function automatic logic [1:0] wol_of(input state_t st);
    logic [1:0] w;
    w = WOL_PLAY;
    case (st)
      S_PAUSE: w = WOL_PAUSE;
      S_WIN:   w = WOL_WIN;
      S_LOSE:  w = WOL_LOSE;
      default: w = WOL_PLAY;
    endcase
    return w;
  endfunction

  state_t               state_q, state_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [LVL_W-1:0]     max_digit_q, max_digit_d;
  logic [1:0]           wol_q, wol_d;
  logic [MISS_W-1:0]    misses_q, misses_d;
  logic [MISS_W-1:0]    guesses_left_q, guesses_left_d;
  logic [TIMER_W-1:0]   time_q, time_d;
  logic [RND_W-1:0]     round_q, round_d;
  logic                 level_up_q, level_up_d;
  logic                 new_target_q, new_target_d;
  logic                 start_q, start_d;
  logic                 lose;
  logic                 tick_applies;

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    misses_d       = misses_q;
    guesses_left_d = guesses_left_q;
    time_d         = time_q;
    round_d        = round_q;
    level_up_d     = 1'b0;
    // The start flag requests the very first target after reset.
    new_target_d   = start_q;
    start_d        = 1'b0;
    lose           = 1'b0;
    tick_applies   = 1'b0;

    case (state_q)
      S_PLAY: begin
        if (guess_valid && guess_correct) begin
          // A correct guess takes precedence; any tick this cycle is dropped.
          if ((32'(round_q) + 1) < ROUNDS_PER_LEVEL) begin
            round_d      = round_q + RND_W'(1);
            new_target_d = 1'b1;
          end else if (32'(level_q) == (NUM_LEVELS - 1)) begin
            round_d = round_q + RND_W'(1);
            state_d = S_WIN;
          end else begin
            // Load the new level's values now so they are visible in the
            // LVLUP cycle together with the strobes.
            state_d        = S_LVLUP;
            level_d        = level_q + LVL_W'(1);
            round_d        = '0;
            misses_d       = '0;
            guesses_left_d = budget(level_q + LVL_W'(1));
            time_d         = TIMER_W'(LEVEL_TIME);
            level_up_d     = 1'b1;
            new_target_d   = 1'b1;
          end
        end else begin
          if (guess_valid) begin
            misses_d       = misses_q + MISS_W'(1);
            guesses_left_d = budget(level_q) - (misses_q + MISS_W'(1));
            if ((misses_q + MISS_W'(1)) == budget(level_q)) begin
              lose = 1'b1;
            end
          end else if (pause) begin
            state_d = S_PAUSE;
          end

          // A tick still counts alongside a wrong guess, but a pause
          // request without a guess swallows it.
          tick_applies = tick && (guess_valid || !pause);
          if (tick_applies && (time_q != '0)) begin
            time_d = time_q - TIMER_W'(1);
            if (time_q == TIMER_W'(1)) begin
              lose = 1'b1;
            end
          end

          if (lose) begin
            state_d = S_LOSE;
          end
        end
      end

      S_PAUSE: begin
        if (!pause) begin
          state_d = S_PLAY;
        end
      end

      S_LVLUP: begin
        state_d = S_PLAY;
      end

      S_WIN, S_LOSE: begin
        state_d = state_q;
      end

      default: begin
        state_d = S_PLAY;
      end
    endcase

    max_digit_d = level_d + LVL_W'(1);
    wol_d       = wol_of(state_d);
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state_q        <= S_PLAY;
      level_q        <= '0;
      max_digit_q    <= LVL_W'(1);
      wol_q          <= WOL_PLAY;
      misses_q       <= '0;
      guesses_left_q <= MISS_W'(BASE_MISSES);
      time_q         <= TIMER_W'(LEVEL_TIME);
      round_q        <= '0;
      level_up_q     <= 1'b0;
      new_target_q   <= 1'b0;
      start_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      max_digit_q    <= max_digit_d;
      wol_q          <= wol_d;
      misses_q       <= misses_d;
      guesses_left_q <= guesses_left_d;
      time_q         <= time_d;
      round_q        <= round_d;
      level_up_q     <= level_up_d;
      new_target_q   <= new_target_d;
      start_q        <= start_d;
    end
  end

  assign level        = level_q;
  assign max_digit    = max_digit_q;
  assign win_or_lose  = wol_q;
  assign guesses_left = guesses_left_q;
  assign time_left    = time_q;
  assign round_count  = round_q;
  assign level_up     = level_up_q;
  assign new_target   = new_target_q;

endmodule

// File: tb/tb_game_level_ctrl.sv
module tb_game_level_ctrl;

  localparam int NL = 3;
  localparam int RPL = 3;

  logic clk = 1'b0;
  logic restart = 1'b0;
  logic guess_valid = 1'b0;
  logic guess_correct = 1'b0;
  logic tick = 1'b0;
  logic pause = 1'b0;

  logic [1:0] o_level     [2];
  logic [1:0] o_max_digit [2];
  logic [1:0] o_wol       [2];
  logic [2:0] o_gl        [2];
  logic [6:0] o_time      [2];
  logic [2:0] o_round     [2];
  logic       o_lu        [2];
  logic       o_nt        [2];

  always #5 clk = ~clk;

  // Instance 0 uses the default 99-tick level; instance 1 a 4-tick level.
  game_level_ctrl u_dut (
    .clk(clk), .restart(restart), .guess_valid(guess_valid),
    .guess_correct(guess_correct), .tick(tick), .pause(pause),
    .level(o_level[0]), .max_digit(o_max_digit[0]), .win_or_lose(o_wol[0]),
    .guesses_left(o_gl[0]), .time_left(o_time[0]), .round_count(o_round[0]),
    .level_up(o_lu[0]), .new_target(o_nt[0])
  );

  game_level_ctrl #(.LEVEL_TIME(4)) u_dut4 (
    .clk(clk), .restart(restart), .guess_valid(guess_valid),
    .guess_correct(guess_correct), .tick(tick), .pause(pause),
    .level(o_level[1]), .max_digit(o_max_digit[1]), .win_or_lose(o_wol[1]),
    .guesses_left(o_gl[1]), .time_left(o_time[1]), .round_count(o_round[1]),
    .level_up(o_lu[1]), .new_target(o_nt[1])
  );

  // ---------------- reference model ----------------
  // mode: 0 playing, 1 paused, 2 level-up, 3 won, 4 lost
  int lt_of [2] = '{99, 4};
  int m_mode [2], m_level [2], m_round [2], m_misses [2], m_time [2];
  int m_lu [2], m_nt [2], m_start [2];

  int n_chk = 0;
  int n_pass = 0;

  function automatic int budget_of(input int lvl);
    return 3 + lvl * 1;
  endfunction

  function automatic int wol_exp(input int mode);
    case (mode)
      1: return 2;
      3: return 1;
      4: return 0;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_level[k] = 0; m_round[k] = 0; m_misses[k] = 0;
      m_time[k] = lt_of[k]; m_lu[k] = 0; m_nt[k] = 0; m_start[k] = 1;
    end
  endtask

  task automatic model_step(input bit gv, input bit gc, input bit tk, input bit pz);
    for (int k = 0; k < 2; k++) begin
      int nt;
      int lu;
      bit lost;
      nt = m_start[k];
      lu = 0;
      lost = 0;
      m_start[k] = 0;
      if (m_mode[k] == 0) begin
        if (gv && gc) begin
          if (m_round[k] + 1 < RPL) begin
            m_round[k]++; nt = 1;
          end else if (m_level[k] == NL - 1) begin
            m_round[k]++; m_mode[k] = 3;
          end else begin
            m_level[k]++; m_round[k] = 0; m_misses[k] = 0;
            m_time[k] = lt_of[k]; m_mode[k] = 2; lu = 1; nt = 1;
          end
        end else begin
          if (gv) begin
            m_misses[k]++;
            if (m_misses[k] >= budget_of(m_level[k])) lost = 1;
          end
          if (tk && (gv || !pz) && m_time[k] > 0) begin
            m_time[k]--;
            if (m_time[k] == 0) lost = 1;
          end
          if (lost) m_mode[k] = 4;
          else if (!gv && pz) m_mode[k] = 1;
        end
      end else if (m_mode[k] == 1) begin
        if (!pz) m_mode[k] = 0;
      end else if (m_mode[k] == 2) begin
        m_mode[k] = 0;
      end
      m_lu[k] = lu;
      m_nt[k] = nt;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("level[%0d]", k), int'(o_level[k]), m_level[k]);
      chk($sformatf("max_digit[%0d]", k), int'(o_max_digit[k]), m_level[k] + 1);
      chk($sformatf("win_or_lose[%0d]", k), int'(o_wol[k]), wol_exp(m_mode[k]));
      chk($sformatf("guesses_left[%0d]", k), int'(o_gl[k]), budget_of(m_level[k]) - m_misses[k]);
      chk($sformatf("time_left[%0d]", k), int'(o_time[k]), m_time[k]);
      chk($sformatf("round_count[%0d]", k), int'(o_round[k]), m_round[k]);
      chk($sformatf("level_up[%0d]", k), int'(o_lu[k]), m_lu[k]);
      chk($sformatf("new_target[%0d]", k), int'(o_nt[k]), m_nt[k]);
    end
  end

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input bit gv, input bit gc, input bit tk, input bit pz);
    guess_valid = gv; guess_correct = gc; tick = tk; pause = pz;
    @(posedge clk);
    if (restart) model_step(gv, gc, tk, pz);
    #1;
  endtask

  task automatic do_reset();
    #2;
    restart = 1'b0;
    model_reset();
    guess_valid = 0; guess_correct = 0; tick = 0; pause = 0;
    repeat (2) @(posedge clk);
    #1;
    restart = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset values, hand-computed.
    chk("rst_level", int'(o_level[0]), 0);
    chk("rst_max_digit", int'(o_max_digit[0]), 1);
    chk("rst_gl", int'(o_gl[0]), 3);
    chk("rst_time", int'(o_time[0]), 99);
    chk("rst_wol", int'(o_wol[0]), 3);
    chk("rst_nt", int'(o_nt[0]), 0);
    restart = 1'b1;

    // Test 1: start pulse, then three correct guesses into LVLUP.
    cyc(0, 0, 0, 0);
    chk("t1_start_nt", int'(o_nt[0]), 1);
    cyc(0, 0, 0, 0);
    chk("t1_idle_nt", int'(o_nt[0]), 0);
    cyc(1, 1, 0, 0);
    chk("t1_g1_nt", int'(o_nt[0]), 1);
    chk("t1_g1_round", int'(o_round[0]), 1);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("t1_g2_nt", int'(o_nt[0]), 1);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("t1_lvlup_level", int'(o_level[0]), 1);
    chk("t1_lvlup_maxd", int'(o_max_digit[0]), 2);
    chk("t1_lvlup_gl", int'(o_gl[0]), 4);
    chk("t1_lvlup_time", int'(o_time[0]), 99);
    chk("t1_lvlup_lu", int'(o_lu[0]), 1);
    chk("t1_lvlup_nt", int'(o_nt[0]), 1);
    chk("t1_lvlup_round", int'(o_round[0]), 0);
    cyc(0, 0, 0, 0);
    chk("t1_after_lu", int'(o_lu[0]), 0);

    // Test 2: six more correct guesses finish the game.
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("t2_wol", int'(o_wol[0]), 1);
    chk("t2_level", int'(o_level[0]), 2);
    chk("t2_round", int'(o_round[0]), 3);
    for (int i = 0; i < 4; i++) cyc(1, i[0], 1, i[1]);
    chk("t2_sticky_wol", int'(o_wol[0]), 1);
    chk("t2_sticky_round", int'(o_round[0]), 3);
    chk("t2_sticky_time", int'(o_time[0]), 99);

    // Test 3: three misses at level 0, the last one with a tick.
    do_reset();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t3_gl2", int'(o_gl[0]), 2);
    cyc(1, 0, 0, 0);
    chk("t3_gl1", int'(o_gl[0]), 1);
    cyc(1, 0, 1, 0);
    chk("t3_gl0", int'(o_gl[0]), 0);
    chk("t3_wol", int'(o_wol[0]), 0);
    chk("t3_time", int'(o_time[0]), 98);
    chk("t3_time4", int'(o_time[1]), 3);
    cyc(1, 1, 1, 0);
    chk("t3_sticky", int'(o_wol[0]), 0);

    // Test 4: four-tick level runs out; then a correct guess on the 4th tick.
    do_reset();
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    chk("t4_time4", int'(o_time[1]), 0);
    chk("t4_wol4", int'(o_wol[1]), 0);
    chk("t4_time99", int'(o_time[0]), 95);
    chk("t4_wol99", int'(o_wol[0]), 3);
    do_reset();
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    cyc(1, 1, 1, 0);
    chk("t4b_time4", int'(o_time[1]), 1);
    chk("t4b_wol4", int'(o_wol[1]), 3);
    chk("t4b_round4", int'(o_round[1]), 1);

    // Test 5: pause freezes everything, then resumes.
    do_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    chk("t5_paused", int'(o_wol[0]), 2);
    for (int i = 0; i < 10; i++) cyc(i[0], i[1], 1, 1);
    chk("t5_frozen_wol", int'(o_wol[0]), 2);
    chk("t5_frozen_time", int'(o_time[0]), 97);
    chk("t5_frozen_gl", int'(o_gl[0]), 3);
    chk("t5_frozen_round", int'(o_round[0]), 0);
    cyc(0, 0, 0, 0);
    chk("t5_resume_wol", int'(o_wol[0]), 3);
    chk("t5_resume_time", int'(o_time[0]), 97);
    cyc(1, 1, 0, 1);
    chk("t5_gp_round", int'(o_round[0]), 1);
    chk("t5_gp_wol", int'(o_wol[0]), 3);
    cyc(0, 0, 0, 1);
    chk("t5_gp_paused", int'(o_wol[0]), 2);
    cyc(0, 0, 0, 0);

    // Test 6: asynchronous reset in the middle of level 1.
    do_reset();
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t6_pre_level", int'(o_level[0]), 1);
    chk("t6_pre_time", int'(o_time[0]), 98);
    #2;
    restart = 1'b0;
    model_reset();
    #1;
    chk("t6_async_level", int'(o_level[0]), 0);
    chk("t6_async_maxd", int'(o_max_digit[0]), 1);
    chk("t6_async_round", int'(o_round[0]), 0);
    chk("t6_async_gl", int'(o_gl[0]), 3);
    chk("t6_async_time", int'(o_time[0]), 99);
    chk("t6_async_wol", int'(o_wol[0]), 3);
    repeat (2) @(posedge clk);
    #1;
    restart = 1'b1;
    cyc(0, 0, 0, 0);
    chk("t6_rel_nt", int'(o_nt[0]), 1);
    cyc(0, 0, 0, 0);
    chk("t6_rel_nt_once", int'(o_nt[0]), 0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/game_level_ctrl.md
Name: game_level_ctrl

Overview:
- Parametrised successor to the three-level guessing-game difficulty FSM.
- Owns the per-level round counter, miss counter and countdown timer internally, rather than taking them as inputs.
- Supports N levels with per-level miss budgets, a pause mode, and one-cycle level-up and new-target strobes.
- Sits between the guess comparator / 1 Hz tick generator and the display and target-generator blocks.

Parameters:
NUM_LEVELS, 3, number of difficulty levels (>=1)
ROUNDS_PER_LEVEL, 3, correct guesses needed to clear a level (>=1)
LVL_W, 2, width of level/max_digit outputs; must hold NUM_LEVELS
RND_W, 3, width of round counter; must hold ROUNDS_PER_LEVEL
MISS_W, 3, width of miss counter/guesses_left
BASE_MISSES, 3, miss budget at level 0 (>=1)
MISS_STEP, 1, extra misses granted per level; BASE_MISSES+(NUM_LEVELS-1)*MISS_STEP must fit MISS_W
TIMER_W, 7, timer width
LEVEL_TIME, 99, ticks allowed per level (>=1, fits TIMER_W)

Ports:
clk  in  1  system clock
restart  in  1  asynchronous active-low reset
guess_valid  in  1  one-cycle strobe: a guess was submitted
guess_correct  in  1  qualifies guess_valid; 1 = correct
tick  in  1  one-cycle timer strobe (1 Hz enable)
pause  in  1  level-sensitive pause request
level  out  LVL_W  current level, 0-based
max_digit  out  LVL_W  level+1, highest digit the target generator may use
win_or_lose  out  2  11 = playing, 10 = paused, 01 = win, 00 = lose
guesses_left  out  MISS_W  budget(level) - misses
time_left  out  TIMER_W  remaining ticks in current level
round_count  out  RND_W  correct guesses in current level
level_up  out  1  one-cycle pulse on level advance
new_target  out  1  one-cycle pulse requesting a fresh target

Behaviour:
- budget(level) = BASE_MISSES + level*MISS_STEP. All outputs are registered.
- States:
  - PLAY
  - PAUSE
  - LVLUP (transient)
  - WIN (sticky)
  - LOSE (sticky)
- Reset (restart=0, asynchronous): state=PLAY, level=0, max_digit=1, round_count=0, misses=0, guesses_left=BASE_MISSES, time_left=LEVEL_TIME, win_or_lose=11, level_up=0, new_target=0.
  - A start flag sets on reset. In the first clock after release, new_target=1 for one cycle.
- PLAY priority per cycle, highest first:
  - guess_valid & guess_correct:
    - round_count+1 < ROUNDS_PER_LEVEL: round_count++, new_target pulses next cycle, stay PLAY.
    - round_count+1 == ROUNDS_PER_LEVEL and level == NUM_LEVELS-1: go WIN, round_count reaches ROUNDS_PER_LEVEL.
    - Otherwise: go LVLUP.
  - guess_valid & !guess_correct: misses++. If misses reaches budget (guesses_left becomes 0), go LOSE.
  - pause=1: go PAUSE.
  - tick: time_left--. If time_left was 1, it becomes 0 and state goes LOSE.
- Simultaneous events in PLAY:
  - Correct guess + final tick: guess wins; tick is dropped that cycle (a LVLUP reload makes it moot).
  - Wrong guess + tick: both apply. LOSE if either condition is met.
  - guess_valid + pause: guess is processed; PAUSE is entered on the next cycle if pause is still 1.
- PAUSE:
  - guess_valid and tick are ignored; counters are frozen; win_or_lose=10.
  - Returns to PLAY the cycle after pause=0.
- LVLUP (exactly one cycle):
  - level++, max_digit=level+1 (new), round_count=0, misses=0, guesses_left=budget(new level), time_left=LEVEL_TIME.
  - level_up=1 and new_target=1 in this same registered cycle.
  - Next state PLAY; inputs are ignored in this state.
- WIN: win_or_lose=01. LOSE: win_or_lose=00. Both hold all counters and ignore all inputs until restart.
- guess_correct is don't-care when guess_valid=0.
- Counters never wrap: round_count saturates at ROUNDS_PER_LEVEL; time_left does not decrement below 0.
- Reset asserted mid-level, mid-pause or in LVLUP returns immediately to reset values.

Test Plan:
1. Defaults (3 levels, 3 rounds): release reset, then 3 correct guesses → new_target pulse after reset, then after guesses 1 and 2. After the 3rd: LVLUP cycle with level=1, max_digit=2, guesses_left=4, time_left=99, level_up=1, new_target=1.
2. Full run: 9 correct guesses across levels → win_or_lose=01 after the 9th, level=2, round_count=3. Further guesses and ticks change nothing.
3. Level 0, 3 wrong guesses → guesses_left 3→2→1→0, win_or_lose=00 on the 3rd. Same cycle as 3rd miss also carries a tick → still LOSE, time_left decremented.
4. LEVEL_TIME=4: 4 ticks → time_left 4→0, LOSE. Repeat with a correct guess (not the level-clearing one) coinciding with the 4th tick → stays PLAY, time_left=1.
5. pause=1 for 10 cycles with ticks and guesses applied → win_or_lose=10, all counters frozen. After pause=0, PLAY resumes with the prior time_left.
6. Assert restart asynchronously mid-level 1, between clock edges → all outputs take reset values immediately. new_target pulses once after release.
